// File: rtl/simd_result_collector.sv
// Result collector: captures four (optionally eight) 32-bit lane results into a FIFO and
// serialises each set as one or two 128-bit beats. Optional COLLECTOR_DROP_CNT_EN adds drop_count.
module simd_result_collector #(
    parameter int DEPTH   = 4,
    parameter int LEVEL_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               res_valid,
    input  logic               res_wide,
    input  logic [31:0]        out_procc0,
    input  logic [31:0]        out_procc1,
    input  logic [31:0]        out_procc2,
    input  logic [31:0]        out_procc3,
    input  logic [31:0]        out_extra_procc0,
    input  logic [31:0]        out_extra_procc1,
    input  logic [31:0]        out_extra_procc2,
    input  logic [31:0]        out_extra_procc3,
    output logic [127:0]       m_data,
    output logic               m_valid,
    output logic               m_last,
    input  logic               m_ready,
    output logic [LEVEL_W-1:0] fifo_level,
`ifdef COLLECTOR_DROP_CNT_EN
    output logic [15:0]        drop_count,
`endif
    output logic               overflow
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = 257;
    localparam int WIDE_B  = 256;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2
    } state_t;

    state_t               state_r;
    logic [ENTRY_W-1:0]   mem_r [DEPTH];
    logic [ENTRY_W-1:0]   hold_r;
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [LEVEL_W-1:0]   level_r;
    logic                 overflow_r;
    logic [ENTRY_W-1:0]   wr_entry_s;
    logic [ENTRY_W-1:0]   rd_entry_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 drop_s;
    logic                 not_empty_s;

    assign fifo_level = level_r;
    assign overflow   = overflow_r;

    // Entry packing, push/drop decision and serialiser pop request.
    always_comb begin
        wr_entry_s  = {res_wide,
                       (res_wide ? {out_extra_procc3, out_extra_procc2,
                                    out_extra_procc1, out_extra_procc0} : 128'd0),
                       out_procc3, out_procc2, out_procc1, out_procc0};
        rd_entry_s  = mem_r[rd_ptr_r];
        // A same-edge pop never frees space for the incoming write.
        push_s      = res_valid && (level_r < LEVEL_W'(DEPTH));
        drop_s      = res_valid && !push_s;
        not_empty_s = (level_r != {LEVEL_W{1'b0}});
        case (state_r)
            ST_IDLE: pop_s = not_empty_s;
            ST_LO:   pop_s = not_empty_s && m_ready && !hold_r[WIDE_B];
            ST_HI:   pop_s = not_empty_s && m_ready;
            default: pop_s = 1'b0;
        endcase
    end

    // FIFO storage; contents are only read while the level says they are valid.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_entry_s;
        end
    end

    // Pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            level_r    <= {LEVEL_W{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LEVEL_W'(1);
                2'b01:   level_r <= level_r - LEVEL_W'(1);
                default: level_r <= level_r;
            endcase
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

`ifdef COLLECTOR_DROP_CNT_EN
    logic [15:0] drop_count_r;
    assign drop_count = drop_count_r;

    // Saturating count of dropped result sets.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_count_r <= 16'd0;
        end else if (drop_s && (drop_count_r != 16'hFFFF)) begin
            drop_count_r <= drop_count_r + 16'd1;
        end else begin
            drop_count_r <= drop_count_r;
        end
    end
`endif

    // Serialiser FSM; beat outputs are registered alongside the state transition.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            hold_r  <= {ENTRY_W{1'b0}};
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            m_data  <= 128'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        hold_r  <= rd_entry_s;
                        state_r <= ST_LO;
                        m_valid <= 1'b1;
                        m_data  <= rd_entry_s[127:0];
                        m_last  <= ~rd_entry_s[WIDE_B];
                    end
                end
                ST_LO: begin
                    if (m_ready) begin
                        if (hold_r[WIDE_B]) begin
                            state_r <= ST_HI;
                            m_data  <= hold_r[255:128];
                            m_last  <= 1'b1;
                        end else if (pop_s) begin
                            hold_r  <= rd_entry_s;
                            m_data  <= rd_entry_s[127:0];
                            m_last  <= ~rd_entry_s[WIDE_B];
                        end else begin
                            state_r <= ST_IDLE;
                            m_valid <= 1'b0;
                            m_last  <= 1'b0;
                        end
                    end
                end
                ST_HI: begin
                    if (m_ready) begin
                        if (pop_s) begin
                            hold_r  <= rd_entry_s;
                            state_r <= ST_LO;
                            m_data  <= rd_entry_s[127:0];
                            m_last  <= ~rd_entry_s[WIDE_B];
                        end else begin
                            state_r <= ST_IDLE;
                            m_valid <= 1'b0;
                            m_last  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    m_valid <= 1'b0;
                    m_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/simd_result_collector.md
# simd_result_collector

Downstream stage of `simd_top_level`. Captures the four per-processor result lanes (`out_procc0..3`, plus `out_extra_procc0..3` when an operation produces them) on a result-valid strobe. Buffers each result set in a small FIFO, then serialises it as one or two 128-bit beats on a valid/ready stream toward the memory controller write path. Runs entirely in the `clk` domain; the `clk_2` fast clock is not used here.

## Interface
- `DEPTH`, 4: FIFO entries (result sets); power of two, ≥2.
- `LEVEL_W`, log2(DEPTH)+1: width of `fifo_level`.

- `clk`  in  1  system clock (same `clk` as `simd_top_level`).
- `reset`  in  1  asynchronous, active-high.
- `res_valid`  in  1  result set present on lane inputs this cycle.
- `res_wide`  in  1  set carries extra lanes; sampled with `res_valid`.
- `out_procc0..3`  in  32 each  primary lane results.
- `out_extra_procc0..3`  in  32 each  extra lane results (high half / remainder).
- `m_data`  out  128  output beat.
- `m_valid`  out  1  beat valid.
- `m_last`  out  1  final beat of current set.
- `m_ready`  in  1  downstream accepts beat.
- `fifo_level`  out  LEVEL_W  stored sets, excluding the set in the holding register.
- `overflow`  out  1  sticky; set when a set is dropped.
- `drop_count`  out  16  present only with `COLLECTOR_DROP_CNT_EN`.

## Operation
- Packing:
  - lo beat = {`out_procc3`, `out_procc2`, `out_procc1`, `out_procc0`}, with `out_procc0` in [31:0].
  - hi beat = {`out_extra_procc3`, …, `out_extra_procc0`}, same ordering.
  - FIFO entry = {wide, hi, lo} (257 bits). hi is stored as zero when `res_wide`=0.
- Write: at a rising edge with `res_valid`=1:
  - if `fifo_level` < `DEPTH` (evaluated before the edge), the entry is pushed;
  - otherwise the set is dropped and `overflow` is set.
  - A pop at the same edge does not make room for that write; there is no pass-through when full.
- Serialiser FSM, states IDLE / LO / HI, with a holding register `hold`:
  - IDLE: `m_valid`=0. If FIFO non-empty: pop into `hold`, go to LO.
  - LO: `m_valid`=1, `m_data`=`hold.lo`, `m_last`=~`hold.wide`. On `m_ready`:
    - if `hold.wide`, go to HI;
    - else if FIFO non-empty, pop into `hold` and stay in LO;
    - else go to IDLE.
  - HI: `m_valid`=1, `m_data`=`hold.hi`, `m_last`=1. On `m_ready`:
    - if FIFO non-empty, pop and go to LO;
    - else go to IDLE.
- `m_data` and `m_last` hold steady while `m_valid`=1 and `m_ready`=0.
- `m_data` is don't-care in IDLE but is driven from `hold` (no X).
- Push and pop at the same edge are both performed; `fifo_level` stays unchanged.
- Pointers wrap modulo `DEPTH`. Full/empty is decided by `fifo_level`, not by pointer equality.
- `overflow` clears only on reset.

## Timing
- Reset values: FSM=IDLE, pointers=0, `fifo_level`=0, `m_valid`=0, `m_last`=0, `m_data`=0, `overflow`=0, `drop_count`=0.
- Latency with FIFO empty and FSM IDLE:
  - set written at edge N;
  - popped at edge N+1;
  - `m_valid`=1 after edge N+1 (2 edges from write to valid).
- Back-to-back throughput with `m_ready`=1: one narrow set per cycle, or one wide set per 2 cycles.
- Wide sets arriving every cycle fill the FIFO and then drop.
- Reset mid-operation: all state is cleared immediately and asynchronously; any beat in flight is lost and `m_valid` falls without waiting for `m_ready`.
- All outputs are registered.

## Configuration
- `COLLECTOR_DROP_CNT_EN` defined:
  - the `drop_count` port exists;
  - it increments by 1 on each dropped set and saturates at 16'hFFFF;
  - it clears on reset.
- Undefined: the `drop_count` port and counter are absent; `overflow` alone reports drops.

## Test plan
- Single narrow set: `out_procc0..3` = 66666666, 55555555, 22222222, 11111111, `res_wide`=0, `m_ready`=1.
  - Expect one beat `m_data`=128'h11111111_22222222_55555555_66666666, with `m_last`=1, `m_valid`=1 exactly 2 edges after the write.
- Wide set: extras = 00000004, 00000003, 00000002, 00000001.
  - Expect lo beat (`m_last`=0), then hi beat 128'h00000001_00000002_00000003_00000004 (`m_last`=1) on the next cycle.
- Backpressure: `m_ready`=0 for 10 cycles while 3 narrow sets are written.
  - `m_data` stays stable and `fifo_level`=2 (one set in `hold`).
  - Release `m_ready`: beats emerge in order, one per cycle.
- Overflow (`DEPTH`=4, `m_ready`=0): write 6 sets.
  - 4 stored + 1 in `hold` = 5 accepted; 6th dropped.
  - `overflow`=1; `drop_count`=1 when `COLLECTOR_DROP_CNT_EN` is defined.
  - Draining yields exactly 5 sets, in order.
- Wrap-around: stream 20 alternating narrow/wide sets with random `m_ready`.
  - Scoreboard matches all beats in order, with no drops while the average input rate is below output capacity.
- Reset mid-burst: assert `reset` while in HI with 2 sets queued.
  - All outputs return to reset values in the same cycle.
  - After release, a new set is delivered correctly.
